uart_rx_fsm: RTL and testbench

Control FSM for the UART receiver. It detects the start edge on rx_in, sequences start/data/parity/stop bit periods, and owns an edge/bit counter. It generates the enables for data sampling, deserializer, start/parity/stop checkers, and raises data_valid when a frame is clean. It sits between the serial line and the RX datapath; the stop checker is driven by its stp_chk_en and feeds back stp_err.

---
 rtl/uart_rx_pkg.sv | 19 +
 rtl/uart_rx_fsm_edge_bit_counter.sv | 34 +++
 rtl/uart_rx_fsm.sv | 113 +++++++++++
 tb/tb_uart_rx_fsm.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver control path.
// FSM state encoding, legal oversampling ratios and counter widths.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    localparam int PRESCALE_8  = 8;
    localparam int PRESCALE_16 = 16;
    localparam int PRESCALE_32 = 32;

    localparam int BIT_CNT_W = 4;

endpackage

// File: rtl/uart_rx_fsm_edge_bit_counter.sv
// Oversample edge counter and frame bit counter for the UART receiver.
// Edge count wraps at prescale-1 and advances the bit count.
module edge_bit_counter
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  en,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_CNT_W-1:0]  bit_cnt,
    output logic                  end_bit
);

    assign end_bit = (edge_cnt == prescale - 1'b1);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (en) begin
            if (end_bit) begin
                edge_cnt <= '0;
                bit_cnt  <= bit_cnt + 1'b1;
            end else begin
                edge_cnt <= edge_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receiver control FSM: start detect, bit sequencing, checker strobes.
// Optional frame_err output enabled by defining UART_RX_FRAME_ERR_EN.
module uart_rx_fsm
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  par_en,
    input  logic                  strt_glitch,
    input  logic                  par_err,
    input  logic                  stp_err,
    output logic                  dat_samp_en,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_CNT_W-1:0]  bit_cnt,
    output logic                  deser_en,
    output logic                  strt_chk_en,
    output logic                  par_chk_en,
    output logic                  stp_chk_en,
    output logic                  data_valid
`ifdef UART_RX_FRAME_ERR_EN
    ,
    output logic                  frame_err
`endif
);

    state_e state, state_nxt;

    logic                  end_bit;
    logic                  at_strobe;
    logic                  frame_ok;
    logic                  cnt_clr;
    logic                  cnt_en;
    logic [PRESCALE_W-1:0] strobe_pt;

    // Sampled bit settles two edges past mid-bit
    assign strobe_pt = (prescale >> 1) + PRESCALE_W'(2);
    assign at_strobe = (edge_cnt == strobe_pt);
    assign frame_ok  = !stp_err && (!par_en || !par_err);

    assign cnt_en  = (state != IDLE);
    assign cnt_clr = (state_nxt == IDLE);

    edge_bit_counter #(
        .PRESCALE_W(PRESCALE_W)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .prescale(prescale),
        .edge_cnt(edge_cnt),
        .bit_cnt (bit_cnt),
        .end_bit (end_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        deser_en    = 1'b0;
        strt_chk_en = 1'b0;
        par_chk_en  = 1'b0;
        stp_chk_en  = 1'b0;
        data_valid  = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
        frame_err   = 1'b0;
`endif
        dat_samp_en = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (!rx_in) state_nxt = START;
            end
            START: begin
                strt_chk_en = at_strobe;
                if (end_bit) begin
                    state_nxt = strt_glitch ? IDLE : DATA;
`ifdef UART_RX_FRAME_ERR_EN
                    frame_err = strt_glitch;
`endif
                end
            end
            DATA: begin
                deser_en = at_strobe;
                if (end_bit && bit_cnt == BIT_CNT_W'(DATA_WIDTH))
                    state_nxt = par_en ? PARITY : STOP;
            end
            PARITY: begin
                par_chk_en = at_strobe;
                if (end_bit) state_nxt = STOP;
            end
            STOP: begin
                stp_chk_en = at_strobe;
                if (end_bit) begin
                    state_nxt  = IDLE;
                    data_valid = frame_ok;
`ifdef UART_RX_FRAME_ERR_EN
                    frame_err  = !frame_ok;
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed self-checking bench for uart_rx_fsm.
// Frames are driven serially; strobes are tallied per scenario.
module tb_uart_rx_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_in;
    logic [5:0] prescale;
    logic       par_en;
    logic       strt_glitch;
    logic       par_err;
    logic       stp_err;
    logic       dat_samp_en;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       deser_en;
    logic       strt_chk_en;
    logic       par_chk_en;
    logic       stp_chk_en;
    logic       data_valid;
`ifdef UART_RX_FRAME_ERR_EN
    logic       frame_err;
`endif

    int checks = 0;
    int failures = 0;

    int cur_ps;
    int strobe_edge;
    int n_deser, n_strt, n_par, n_stp, n_dv, n_dsen, n_ferr;
    int deser_bad, strobe_bad, overlap;
    int dv_bit, dv_edge, par_bit, par_edge;
    int dsen_last_bit, dsen_last_edge;
    int smp, dv_t0, dv_t1;
    logic [15:0] deser_mask;

    uart_rx_fsm dut (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx_in),
        .prescale   (prescale),
        .par_en     (par_en),
        .strt_glitch(strt_glitch),
        .par_err    (par_err),
        .stp_err    (stp_err),
        .dat_samp_en(dat_samp_en),
        .edge_cnt   (edge_cnt),
        .bit_cnt    (bit_cnt),
        .deser_en   (deser_en),
        .strt_chk_en(strt_chk_en),
        .par_chk_en (par_chk_en),
        .stp_chk_en (stp_chk_en),
        .data_valid (data_valid)
`ifdef UART_RX_FRAME_ERR_EN
        ,
        .frame_err  (frame_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic clear_mon();
        n_deser = 0; n_strt = 0; n_par = 0; n_stp = 0;
        n_dv = 0; n_dsen = 0; n_ferr = 0;
        deser_bad = 0; strobe_bad = 0; overlap = 0;
        dv_bit = -1; dv_edge = -1; par_bit = -1; par_edge = -1;
        dsen_last_bit = -1; dsen_last_edge = -1;
        smp = 0; dv_t0 = -1; dv_t1 = -1;
        deser_mask = '0;
    endtask

    task automatic sample();
        smp++;
        if (dat_samp_en) begin
            n_dsen++;
            dsen_last_bit = int'(bit_cnt);
            dsen_last_edge = int'(edge_cnt);
        end
        if (deser_en) begin
            n_deser++;
            deser_mask[bit_cnt] = 1'b1;
            if (int'(edge_cnt) != strobe_edge) deser_bad++;
        end
        if (strt_chk_en) begin
            n_strt++;
            if (int'(edge_cnt) != strobe_edge || bit_cnt != 4'd0) strobe_bad++;
        end
        if (stp_chk_en) begin
            n_stp++;
            if (int'(edge_cnt) != strobe_edge) strobe_bad++;
        end
        if (par_chk_en) begin
            n_par++;
            par_bit = int'(bit_cnt);
            par_edge = int'(edge_cnt);
        end
        if (data_valid) begin
            n_dv++;
            dv_bit = int'(bit_cnt);
            dv_edge = int'(edge_cnt);
            if (dv_t0 < 0) dv_t0 = smp;
            else dv_t1 = smp;
        end
`ifdef UART_RX_FRAME_ERR_EN
        if (frame_err) n_ferr++;
        if (frame_err && data_valid) overlap++;
`endif
    endtask

    task automatic set_ps(input int ps);
        cur_ps = ps;
        prescale = 6'(ps);
        strobe_edge = ps / 2 + 2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sample();
            rx_in = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input bit par);
        logic [10:0] bits;
        int nb;
        nb = par ? 11 : 10;
        bits = '1;
        bits[0] = 1'b0;
        bits[8:1] = d;
        if (par) bits[9] = ^d;
        for (int b = 0; b < nb; b++) begin
            for (int e = 0; e < cur_ps; e++) begin
                @(negedge clk);
                sample();
                rx_in = bits[b];
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx_in = 1'b1;
        set_ps(8);
        par_en = 1'b0; strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({edge_cnt, bit_cnt} !== 10'd0) begin
            failures++;
            $display("FAIL reset_counts got=%h want=0", {edge_cnt, bit_cnt});
        end
        checks++;
        if ({dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid} !== 6'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=000000",
                     {dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid});
        end
    endtask

    task automatic test_clean_p8();
        set_ps(8);
        par_en = 1'b0;
        clear_mon();
        send_frame(8'h55, 1'b0);
        idle(3);
        checks++;
        if (n_deser != 8 || deser_bad != 0) begin
            failures++;
            $display("FAIL p8_deser got=%0d bad=%0d want=8 bad=0", n_deser, deser_bad);
        end
        checks++;
        if (deser_mask !== 16'h01FE) begin
            failures++;
            $display("FAIL p8_deser_bits got=%h want=01fe", deser_mask);
        end
        checks++;
        if (n_dv != 1 || dv_bit != 9 || dv_edge != 7) begin
            failures++;
            $display("FAIL p8_valid got n=%0d bit=%0d edge=%0d want 1/9/7", n_dv, dv_bit, dv_edge);
        end
        checks++;
        if (n_strt != 1 || n_stp != 1 || n_par != 0 || strobe_bad != 0) begin
            failures++;
            $display("FAIL p8_chk got strt=%0d stp=%0d par=%0d bad=%0d want 1/1/0/0",
                     n_strt, n_stp, n_par, strobe_bad);
        end
        checks++;
        if (dat_samp_en !== 1'b0 || edge_cnt !== 6'd0 || bit_cnt !== 4'd0) begin
            failures++;
            $display("FAIL p8_idle got dsen=%b e=%0d b=%0d want 0/0/0", dat_samp_en, edge_cnt, bit_cnt);
        end
    endtask

    task automatic test_parity_p16();
        set_ps(16);
        par_en = 1'b1;
        par_err = 1'b0;
        clear_mon();
        send_frame(8'hA3, 1'b1);
        idle(3);
        checks++;
        if (n_par != 1 || par_bit != 9 || par_edge != 10) begin
            failures++;
            $display("FAIL p16_par got n=%0d bit=%0d edge=%0d want 1/9/10", n_par, par_bit, par_edge);
        end
        checks++;
        if (n_dv != 1 || dv_bit != 10 || dv_edge != 15) begin
            failures++;
            $display("FAIL p16_valid got n=%0d bit=%0d edge=%0d want 1/10/15", n_dv, dv_bit, dv_edge);
        end
        checks++;
        if (n_deser != 8 || deser_bad != 0 || n_stp != 1 || strobe_bad != 0) begin
            failures++;
            $display("FAIL p16_strobes got deser=%0d bad=%0d stp=%0d sbad=%0d want 8/0/1/0",
                     n_deser, deser_bad, n_stp, strobe_bad);
        end
        par_err = 1'b1;
        clear_mon();
        send_frame(8'hA3, 1'b1);
        idle(3);
        checks++;
        if (n_dv != 0 || n_dsen != 176) begin
            failures++;
            $display("FAIL p16_par_err got dv=%0d dsen=%0d want 0/176", n_dv, n_dsen);
        end
`ifdef UART_RX_FRAME_ERR_EN
        checks++;
        if (n_ferr != 1 || overlap != 0) begin
            failures++;
            $display("FAIL p16_frame_err got=%0d ovl=%0d want 1/0", n_ferr, overlap);
        end
`endif
        par_err = 1'b0;
        par_en = 1'b0;
    endtask

    task automatic test_start_glitch();
        set_ps(8);
        strt_glitch = 1'b1;
        clear_mon();
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            sample();
            rx_in = (i < 2) ? 1'b0 : 1'b1;
        end
        checks++;
        if (n_dsen != 8 || dsen_last_bit != 0 || dsen_last_edge != 7) begin
            failures++;
            $display("FAIL glitch_abort got dsen=%0d bit=%0d edge=%0d want 8/0/7",
                     n_dsen, dsen_last_bit, dsen_last_edge);
        end
        checks++;
        if (n_deser != 0 || n_dv != 0 || n_strt != 1) begin
            failures++;
            $display("FAIL glitch_strobes got deser=%0d dv=%0d strt=%0d want 0/0/1", n_deser, n_dv, n_strt);
        end
`ifdef UART_RX_FRAME_ERR_EN
        checks++;
        if (n_ferr != 1) begin
            failures++;
            $display("FAIL glitch_frame_err got=%0d want 1", n_ferr);
        end
`endif
        strt_glitch = 1'b0;
    endtask

    task automatic test_stop_err();
        set_ps(32);
        stp_err = 1'b1;
        clear_mon();
        send_frame(8'h96, 1'b0);
        idle(3);
        checks++;
        if (n_dv != 0 || n_stp != 1 || strobe_bad != 0) begin
            failures++;
            $display("FAIL p32_stop_err got dv=%0d stp=%0d bad=%0d want 0/1/0", n_dv, n_stp, strobe_bad);
        end
        checks++;
        if (n_dsen != 320 || dsen_last_bit != 9 || dsen_last_edge != 31) begin
            failures++;
            $display("FAIL p32_to_idle got dsen=%0d bit=%0d edge=%0d want 320/9/31",
                     n_dsen, dsen_last_bit, dsen_last_edge);
        end
        checks++;
        if (n_deser != 8 || deser_bad != 0) begin
            failures++;
            $display("FAIL p32_deser got=%0d bad=%0d want 8/0", n_deser, deser_bad);
        end
        stp_err = 1'b0;
    endtask

    task automatic test_back_to_back();
        set_ps(8);
        clear_mon();
        send_frame(8'h00, 1'b0);
        send_frame(8'hFF, 1'b0);
        idle(4);
        checks++;
        if (n_dv != 2 || n_deser != 16) begin
            failures++;
            $display("FAIL b2b_counts got dv=%0d deser=%0d want 2/16", n_dv, n_deser);
        end
        checks++;
        if (dv_t1 - dv_t0 != 81) begin
            failures++;
            $display("FAIL b2b_gap got=%0d want 81", dv_t1 - dv_t0);
        end
        checks++;
        if (n_dsen != 160) begin
            failures++;
            $display("FAIL b2b_active got=%0d want 160", n_dsen);
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        set_ps(8);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (dat_samp_en && bit_cnt == 4'd4) found = 1'b1;
            else rx_in = (i == 0) ? 1'b0 : 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL rst_mid_reach got=timeout want=bit4");
        end
        rst = 1'b1;
        rx_in = 1'b1;
        @(negedge clk);
        checks++;
        if ({dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid,
             edge_cnt, bit_cnt} !== 16'd0) begin
            failures++;
            $display("FAIL rst_mid_outputs got=%h want=0",
                     {dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid,
                      edge_cnt, bit_cnt});
        end
        rst = 1'b0;
        idle(2);
        clear_mon();
        send_frame(8'h3C, 1'b0);
        idle(3);
        checks++;
        if (n_dv != 1 || n_deser != 8 || dv_bit != 9 || deser_mask !== 16'h01FE) begin
            failures++;
            $display("FAIL rst_mid_recover got dv=%0d deser=%0d bit=%0d mask=%h want 1/8/9/01fe",
                     n_dv, n_deser, dv_bit, deser_mask);
        end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_clean_p8();
        test_parity_p16();
        test_start_glitch();
        test_stop_err();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
